// File: rtl/vencoder_pkg.sv
// vencoder_pkg: shared types, generator presets and parity helper for the convolutional encoder
package vencoder_pkg;

    typedef enum logic [1:0] {IDLE, SER, FLUSH} state_t;

    localparam logic [5:0]  G_K3 = {3'b101, 3'b111};
    localparam logic [13:0] G_K7 = {7'o133, 7'o171};

    function automatic logic parity(input logic [8:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/vencoder_ser.sv
// vencoder_ser: N-bit parallel-load serialiser, LSB first, with last-bit flag
module vencoder_ser #(
    parameter int N = 2
) (
    input  logic         Clock,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] data,
    output logic         out_bit,
    output logic         out_valid,
    output logic         last_bit
);

    localparam int CW = $clog2(N);

    logic [N-1:0]  sh;
    logic [CW-1:0] cnt;

    assign out_bit  = sh[0];
    assign last_bit = out_valid && (cnt == CW'(N-1));

    // load a codeword, shift it out one bit per cycle, clear the line when done
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            sh        <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            sh        <= data;
            cnt       <= '0;
            out_valid <= 1'b1;
        end else if (last_bit) begin
            sh        <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else if (out_valid) begin
            sh        <= sh >> 1;
            cnt       <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vencoder_n.sv
// vencoder_n: rate-1/N convolutional encoder with serial output and optional zero-tail flush
module vencoder_n
    import vencoder_pkg::*;
#(
    parameter int             K       = 3,
    parameter int             N       = 2,
    parameter logic [N*K-1:0] GEN     = 6'b101_111,
    parameter int             TAIL_EN = 1
) (
    input  logic Clock,
    input  logic reset,
    input  logic in_valid,
    input  logic in_bit,
    input  logic in_last,
    output logic in_ready,
    output logic out_bit,
    output logic out_valid,
    output logic busy
);

    if (K < 2 || K > 9 || N < 2 || N > 8) begin : g_bad_size
        $error("vencoder_n: K must be 2..9 and N must be 2..8");
    end

    state_t       state, state_n;
    logic [K-2:0] sr;
    logic [3:0]   tail_cnt;
    logic [K-1:0] w;
    logic [N-1:0] code;
    logic         accept, flush_load, load, din, last_bit;

    assign in_ready   = !reset && (tail_cnt == 4'd0) && (state != FLUSH) && (!out_valid || last_bit);
    assign accept     = in_valid && in_ready;
    assign flush_load = (tail_cnt != 4'd0) && (!out_valid || last_bit);
    assign load       = accept || flush_load;
    assign din        = accept ? in_bit : 1'b0;
    assign w          = {din, sr};
    assign busy       = state != IDLE;

    for (genvar j = 0; j < N; j++) begin : g_code
        if (GEN[j*K +: K] == '0) begin : g_zero_gen
            $error("vencoder_n: generator polynomial is all zero");
        end
        assign code[j] = parity(9'(GEN[j*K +: K] & w));
    end

    // next state: a new bit keeps serialising, a pending tail flushes, otherwise drain to idle
    always_comb begin
        state_n = state;
        if (accept)
            state_n = SER;
        else if (flush_load)
            state_n = FLUSH;
        else if (last_bit)
            state_n = IDLE;
    end

    // state register, shift register of past inputs and remaining tail length
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sr       <= '0;
            tail_cnt <= '0;
        end else begin
            state <= state_n;
            if (load)
                sr <= w[K-1:1];
            if (accept && in_last && (TAIL_EN != 0))
                tail_cnt <= 4'(K-1);
            else if (flush_load)
                tail_cnt <= tail_cnt - 4'd1;
        end
    end

    vencoder_ser #(.N(N)) u_ser (
        .Clock     (Clock),
        .reset     (reset),
        .load      (load),
        .data      (code),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .last_bit  (last_bit)
    );

endmodule
